// File: rtl/cont4bits2.sv
// cont4bits2 -- 4-bit wrap-around counter with a terminal-count flag.
//
// Counts from 0 up to MAX_COUNT and wraps to 0. TC is high for the cycle in
// which the counter is enabled and about to wrap, so it can drive the enable
// of a cascaded next-stage counter directly.
//
// Optional feature: define CONT4BITS2_UPDOWN_EN to add the `updown` port
// (1 = up, 0 = down). Down counting runs from MAX_COUNT to 0 and wraps back
// to MAX_COUNT; TC then flags Q == 0. With the macro undefined the counter
// counts up only. Port order, reset and timing are the same in both builds.
//
// Handshake: none. `enable` and `updown` are plain level controls sampled on
// the rising clock edge; the caller keeps them synchronous to clk.
module cont4bits2 #(
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
`ifdef CONT4BITS2_UPDOWN_EN
  input  logic       updown,
`endif
  output logic [3:0] Q,
  output logic       TC
);

  // Terminal value in the counter's own width; legal MAX_COUNT is 1..15.
  localparam logic [3:0] C_MAX = 4'(MAX_COUNT);

  logic [3:0] r_q;
  logic       w_count_up;
  logic       w_at_top;
  logic       w_above_top;
  logic       w_at_bottom;
  logic       w_wrap;
  logic [3:0] w_q_next;

  // Direction select: the down path only exists when the feature is built in.
`ifdef CONT4BITS2_UPDOWN_EN
  assign w_count_up = updown;
`else
  assign w_count_up = 1'b1;
`endif

  // Compare the current count against the two wrap points. Values above
  // MAX_COUNT cannot be reached by counting, but if one is present (e.g.
  // after an upset) the next up-count edge must still return to 0.
  assign w_at_top    = (r_q == C_MAX);
  assign w_above_top = (r_q >  C_MAX);
  assign w_at_bottom = (r_q == 4'd0);

  // Wrap condition for the selected direction.
  always_comb begin
    w_wrap = 1'b0;
    if (w_count_up) begin
      w_wrap = w_at_top;
    end else begin
      w_wrap = w_at_bottom;
    end
  end

  // Next count value when enabled; direction changes take effect on the very
  // next edge because nothing here is pipelined.
  always_comb begin
    w_q_next = r_q;
    if (w_count_up) begin
      if (w_at_top || w_above_top) begin
        w_q_next = 4'd0;
      end else begin
        w_q_next = r_q + 4'd1;
      end
    end else begin
      if (w_at_bottom) begin
        w_q_next = C_MAX;
      end else begin
        w_q_next = r_q - 4'd1;
      end
    end
  end

  // Count register: async clear, hold when disabled, step when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= 4'd0;
    end else if (enable) begin
      r_q <= w_q_next;
    end
  end

  assign Q  = r_q;

  // Zero-latency terminal count, gated by enable so it can feed a cascade.
  assign TC = enable & w_wrap;

endmodule

// File: tb/tb_cont4bits2.sv
// Directed testbench for cont4bits2. Two instances: dut_a with the default
// MAX_COUNT (15) and dut_b with MAX_COUNT = 9. When CONT4BITS2_UPDOWN_EN is
// defined the down-count sequence on dut_a is exercised as well.
module tb_cont4bits2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n_a;
  logic       enable_a;
  logic [3:0] q_a;
  logic       tc_a;

  logic       reset_n_b;
  logic       enable_b;
  logic [3:0] q_b;
  logic       tc_b;

`ifdef CONT4BITS2_UPDOWN_EN
  logic       updown_a;
  logic       updown_b;
`endif

  cont4bits2 #(.MAX_COUNT(15)) dut_a (
    .clk     (clk),
    .reset_n (reset_n_a),
    .enable  (enable_a),
`ifdef CONT4BITS2_UPDOWN_EN
    .updown  (updown_a),
`endif
    .Q       (q_a),
    .TC      (tc_a)
  );

  cont4bits2 #(.MAX_COUNT(9)) dut_b (
    .clk     (clk),
    .reset_n (reset_n_b),
    .enable  (enable_b),
`ifdef CONT4BITS2_UPDOWN_EN
    .updown  (updown_b),
`endif
    .Q       (q_b),
    .TC      (tc_b)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] cnt;
    logic       en_r;

    reset_n_a = 1'b0;
    enable_a  = 1'b0;
    reset_n_b = 1'b0;
    enable_b  = 1'b0;
`ifdef CONT4BITS2_UPDOWN_EN
    updown_a  = 1'b1;
    updown_b  = 1'b1;
`endif
    #1;
    check("reset_q", q_a, 4'd0);
    check("reset_tc", {3'b0, tc_a}, 4'd0);
    step();
    step();

    // Release reset away from the clock edge.
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;

    // Hold: five edges with enable low.
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_q", q_a, 4'd0);
      check("hold_tc", {3'b0, tc_a}, 4'd0);
    end

    // Up count 0..15: first increment appears one edge after enable rises.
    enable_a = 1'b1;
    #1;
    check("up_tc_at0", {3'b0, tc_a}, 4'd0);
    for (int i = 1; i <= 15; i++) begin
      step();
      check("up_q", q_a, 4'(i));
      check("up_tc", {3'b0, tc_a}, (i == 15) ? 4'd1 : 4'd0);
    end
    // TC depends on enable combinationally.
    enable_a = 1'b0;
    #1;
    check("tc_gated_by_enable", {3'b0, tc_a}, 4'd0);
    enable_a = 1'b1;
    #1;
    check("tc_reenabled", {3'b0, tc_a}, 4'd1);
    step();
    check("wrap_q", q_a, 4'd0);
    check("wrap_tc", {3'b0, tc_a}, 4'd0);

    // Count to 7, then assert reset mid-count: Q clears without a clock edge.
    for (int i = 1; i <= 7; i++) step();
    check("pre_reset_q", q_a, 4'd7);
    reset_n_a = 1'b0;
    #1;
    check("async_reset_q", q_a, 4'd0);
    enable_a = 1'b0;
    #1;
    check("reset_tc_en0", {3'b0, tc_a}, 4'd0);
    // Reset overrides enable across an edge.
    enable_a = 1'b1;
    step();
    check("reset_override_q", q_a, 4'd0);
    reset_n_a = 1'b1;
    step();
    check("resume_after_reset_q", q_a, 4'd1);

    // Pseudo-random enable over 10 edges, starting from a clean 0.
    reset_n_a = 1'b0;
    #1;
    reset_n_a = 1'b1;
    cnt = 4'd0;
    for (int i = 0; i < 10; i++) begin
      en_r = 1'($urandom_range(0, 1));
      enable_a = en_r;
      if (en_r) cnt = cnt + 4'd1;
      exp_q.push_back(cnt);
      step();
      check("rand_en_q", q_a, exp_q.pop_front());
    end
    enable_a = 1'b0;

    // MAX_COUNT = 9: sequence 0..9,0 with TC only at 9.
    enable_b = 1'b1;
    #1;
    check("p9_q0", q_b, 4'd0);
    check("p9_tc0", {3'b0, tc_b}, 4'd0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("p9_q", q_b, (i == 10) ? 4'd0 : 4'(i));
      check("p9_tc", {3'b0, tc_b}, (i == 9) ? 4'd1 : 4'd0);
    end
    enable_b = 1'b0;

`ifdef CONT4BITS2_UPDOWN_EN
    // Down count from reset: 0 -> 15, 14, ... 0 -> 15.
    reset_n_a = 1'b0;
    #1;
    reset_n_a = 1'b1;
    updown_a  = 1'b0;
    enable_a  = 1'b1;
    #1;
    check("down_tc_at0", {3'b0, tc_a}, 4'd1);
    step();
    check("down_wrap_q", q_a, 4'd15);
    check("down_wrap_tc", {3'b0, tc_a}, 4'd0);
    for (int i = 14; i >= 0; i--) begin
      step();
      check("down_q", q_a, 4'(i));
      check("down_tc", {3'b0, tc_a}, (i == 0) ? 4'd1 : 4'd0);
    end
    step();
    check("down_rewrap_q", q_a, 4'd15);
    // Direction change takes effect on the next edge.
    updown_a = 1'b1;
    #1;
    check("dir_up_tc_at15", {3'b0, tc_a}, 4'd1);
    step();
    check("dir_up_q", q_a, 4'd0);
    // MAX_COUNT = 9 down wrap.
    updown_b = 1'b0;
    enable_b = 1'b1;
    step();
    check("p9_down_wrap_q", q_b, 4'd9);
    enable_b = 1'b0;
    enable_a = 1'b0;
`endif

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cont4bits2.md
CONT4BITS2 -- requirements
Module: cont4bits2

Interface
REQ-001 Parameter: MAX_COUNT, default 15, terminal (highest) count value; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  count enable; active high.
REQ-005 updown  input  1  direction (1 = up, 0 = down); present only when CONT4BITS2_UPDOWN_EN is defined.
REQ-006 Q  output  4  current count value, registered.
REQ-007 TC  output  1  terminal count flag, combinational from Q, enable and direction.

Function
REQ-008 Q SHALL update only on rising clk edges while reset_n is high.
REQ-009 enable = 0: Q SHALL hold its value.
REQ-010 enable = 1, counting up: Q SHALL increment by 1 per cycle.
REQ-011 Up-count wrap: enable = 1 and Q = MAX_COUNT SHALL load Q = 0 on the next edge.
REQ-012 enable = 1, counting down (macro only): Q SHALL decrement by 1 per cycle.
REQ-013 Down-count wrap (macro only): enable = 1 and Q = 0 SHALL load Q = MAX_COUNT.
REQ-014 Up-count TC: TC = enable AND (Q == MAX_COUNT).
REQ-015 Down-count TC (macro only): TC = enable AND (Q == 0).
REQ-016 TC SHALL have zero latency, combinational, with no glitch-free guarantee required.
REQ-017 TC SHALL be usable as the enable of a cascaded next-stage counter.
REQ-018 Counting latency: the first increment SHALL appear one edge after enable rises.
REQ-019 A change of updown SHALL take effect at the next edge; no extra pipeline stage.
REQ-020 Q values above MAX_COUNT, when MAX_COUNT < 15, are not reachable by counting.
REQ-021 If such a value is present, the next enabled up-count edge SHALL load 0.
REQ-022 enable and updown are synchronous to clk; no internal synchronisers.

Reset
REQ-023 reset_n low SHALL force Q = 0 immediately, without waiting for a clock edge.
REQ-024 TC SHALL be 0 during reset whenever enable = 0 or, in up mode, MAX_COUNT != 0.
REQ-025 Reset asserted mid-count SHALL override enable and updown.
REQ-026 Counting resumes on the first rising edge after reset_n returns high, with enable = 1.
REQ-027 Reset release SHALL be assumed synchronous to clk (away from the active edge) by the integrator.

Configuration
REQ-028 Macro CONT4BITS2_UPDOWN_EN defined: the updown port exists and REQ-012/013/015 apply.
REQ-029 Macro not defined: no updown port; the counter counts up only; TC per REQ-014.
REQ-030 Both configurations SHALL be otherwise identical in port order, reset and timing.

Verification
REQ-031 Reset: reset_n = 0 mid-count at Q = 7 -> Q = 0 immediately; TC = 0 with enable = 0.
REQ-032 Hold: reset_n = 1, enable = 0 for 5 edges -> Q stays 0, TC = 0.
REQ-033 Up count: enable = 1 for 15 edges -> Q = 15 and TC = 1; the 16th edge gives Q = 0 and TC = 0.
REQ-034 Random enable: 10 edges with pseudo-random enable -> Q equals the number of edges sampled with enable = 1, modulo 16.
REQ-035 Parameter: MAX_COUNT = 9, enable = 1 -> sequence 0..9,0; TC = 1 only at Q = 9.
REQ-036 Down count (macro defined): updown = 0, enable = 1 from reset -> Q = 15, 14, ...; TC = 1 at Q = 0 and wraps to 15.
